// File: rtl/teclado_atm.sv
// teclado_atm: keypad front-end for the ATM controller.
// Turns keypad presses into PIN digit strobes, the transaction type and a
// binary amount built from decimal keys. It follows the session by watching
// the controller's status outputs.
// Optional feature: define TECLADO_TIMEOUT_EN to abandon an idle session
// after TIMEOUT_CICLOS cycles without a key event.
module teclado_atm #(
    parameter int N_PIN          = 4,
    parameter int MAX_DIGITOS    = 9,
    parameter int TIMEOUT_CICLOS = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  tecla,
    input  logic        tecla_valida,
    input  logic        tarjeta_recibida,
    input  logic        pin_incorrecto,
    input  logic        bloqueo,
    input  logic        balance_actualizado,
    input  logic        entregar_dinero,
    input  logic        fondos_insuficientes,
    output logic [3:0]  digito,
    output logic        digito_stb,
    output logic        tipo_trans,
    output logic [31:0] monto,
    output logic        monto_stb,
    output logic        error_tecla
);

    localparam logic [2:0] ESPERA  = 3'd0;
    localparam logic [2:0] PIN     = 3'd1;
    localparam logic [2:0] TIPO    = 3'd2;
    localparam logic [2:0] MONTO   = 3'd3;
    localparam logic [2:0] BLOQUEO = 3'd4;

    localparam int CNT_W  = $clog2(N_PIN + 1);
    localparam int NDIG_W = $clog2(MAX_DIGITOS + 1);
    localparam logic [CNT_W-1:0]  CNT_ULTIMO = CNT_W'(N_PIN - 1);
    localparam logic [NDIG_W-1:0] NDIG_MAX   = NDIG_W'(MAX_DIGITOS);

    logic [2:0]        r_estado;
    logic              r_prev;
    logic [CNT_W-1:0]  r_cnt;
    logic [NDIG_W-1:0] r_ndig;
    logic [31:0]       r_acc;
    logic [3:0]        r_digito;
    logic              r_digito_stb;
    logic              r_tipo;
    logic [31:0]       r_monto;
    logic              r_monto_stb;
    logic              r_error;

    logic        w_evt;
    logic        w_fin;
    logic        w_es_digito;
    logic [31:0] w_acc_next;
    logic        w_timeout;

    assign w_evt       = tecla_valida & ~r_prev;
    assign w_fin       = balance_actualizado | entregar_dinero | fondos_insuficientes;
    assign w_es_digito = (tecla <= 4'd9);
    // acc*10 as two shifts; at most MAX_DIGITOS decimal digits so no overflow
    assign w_acc_next  = (r_acc << 3) + (r_acc << 1) + {28'd0, tecla};

`ifdef TECLADO_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [IDLE_W-1:0] IDLE_ULTIMO = IDLE_W'(TIMEOUT_CICLOS - 1);

    logic [IDLE_W-1:0] r_idle;
    logic              w_activo;

    assign w_activo  = (r_estado == PIN) || (r_estado == TIPO) || (r_estado == MONTO);
    assign w_timeout = w_activo && !w_evt && (r_idle == IDLE_ULTIMO);

    // Inactivity counter: runs only while a session is collecting keys
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idle <= '0;
        end else if (!w_activo || w_evt || w_timeout) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Previous key level, used to turn a held key into a single event
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= tecla_valida;
        end
    end

    // Session FSM: controller events first, then the key handling of each state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_estado     <= ESPERA;
            r_cnt        <= '0;
            r_ndig       <= '0;
            r_acc        <= '0;
            r_digito     <= '0;
            r_digito_stb <= 1'b0;
            r_tipo       <= 1'b0;
            r_monto      <= '0;
            r_monto_stb  <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_digito_stb <= 1'b0;
            r_monto_stb  <= 1'b0;
            r_error      <= 1'b0;
            if (bloqueo) begin
                r_estado <= BLOQUEO;
            end else if (r_estado == BLOQUEO) begin
                // locked: only reset releases the block
                r_estado <= BLOQUEO;
            end else if (pin_incorrecto) begin
                r_estado <= PIN;
                r_cnt    <= '0;
                r_acc    <= '0;
                r_ndig   <= '0;
            end else if (w_fin) begin
                r_estado <= ESPERA;
            end else if (w_timeout) begin
                r_estado <= ESPERA;
                r_error  <= 1'b1;
                r_cnt    <= '0;
                r_acc    <= '0;
                r_ndig   <= '0;
            end else begin
                case (r_estado)
                    ESPERA: begin
                        if (tarjeta_recibida) begin
                            r_estado <= PIN;
                            r_cnt    <= '0;
                            r_acc    <= '0;
                            r_ndig   <= '0;
                        end
                    end
                    PIN: begin
                        if (w_evt) begin
                            if (w_es_digito) begin
                                r_digito     <= tecla;
                                r_digito_stb <= 1'b1;
                                r_cnt        <= r_cnt + 1'b1;
                                if (r_cnt == CNT_ULTIMO) begin
                                    r_estado <= TIPO;
                                end
                            end else begin
                                r_error <= 1'b1;
                            end
                        end
                    end
                    TIPO: begin
                        if (w_evt) begin
                            if (tecla == 4'd12) begin
                                r_tipo   <= 1'b0;
                                r_estado <= MONTO;
                            end else if (tecla == 4'd13) begin
                                r_tipo   <= 1'b1;
                                r_estado <= MONTO;
                            end else begin
                                r_error <= 1'b1;
                            end
                        end
                    end
                    MONTO: begin
                        if (w_evt) begin
                            if (w_es_digito) begin
                                if (r_ndig == NDIG_MAX) begin
                                    r_error <= 1'b1;
                                end else begin
                                    r_acc  <= w_acc_next;
                                    r_ndig <= r_ndig + 1'b1;
                                end
                            end else if (tecla == 4'd10) begin
                                r_acc  <= '0;
                                r_ndig <= '0;
                            end else if (tecla == 4'd11) begin
                                if (r_ndig != '0) begin
                                    r_monto     <= r_acc;
                                    r_monto_stb <= 1'b1;
                                    r_estado    <= ESPERA;
                                end else begin
                                    r_error <= 1'b1;
                                end
                            end else if ((tecla == 4'd12) || (tecla == 4'd13)) begin
                                r_error <= 1'b1;
                            end
                        end
                    end
                    default: r_estado <= ESPERA;
                endcase
            end
        end
    end

    assign digito      = r_digito;
    assign digito_stb  = r_digito_stb;
    assign tipo_trans  = r_tipo;
    assign monto       = r_monto;
    assign monto_stb   = r_monto_stb;
    assign error_tecla = r_error;

endmodule

// File: tb/tb_teclado_atm.sv
// Testbench for teclado_atm: directed sessions plus randomized sessions,
// all checked against a key-by-key behavioural model of the keypad session.
module tb_teclado_atm;

    localparam int N_PIN   = 4;
    localparam int MAX_DIG = 9;
    localparam int TMO     = 1000;

    // model session phases
    localparam int S_IDLE = 0;
    localparam int S_PIN  = 1;
    localparam int S_TYPE = 2;
    localparam int S_AMT  = 3;
    localparam int S_LOCK = 4;

    // controller stimulus selectors
    localparam int C_BLOQ = 0;
    localparam int C_PINX = 1;
    localparam int C_BAL  = 2;
    localparam int C_ENT  = 3;
    localparam int C_FON  = 4;
    localparam int C_CARD = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  tecla = '0;
    logic        tecla_valida = 1'b0;
    logic        tarjeta_recibida = 1'b0;
    logic        pin_incorrecto = 1'b0;
    logic        bloqueo = 1'b0;
    logic        balance_actualizado = 1'b0;
    logic        entregar_dinero = 1'b0;
    logic        fondos_insuficientes = 1'b0;
    logic [3:0]  digito;
    logic        digito_stb;
    logic        tipo_trans;
    logic [31:0] monto;
    logic        monto_stb;
    logic        error_tecla;

    int n_chk = 0;
    int n_err = 0;

    // model state
    int     m_st;
    int     m_cnt;
    int     m_ndig;
    longint m_acc;
    longint m_monto;
    int     m_tipo;
    int     m_dig;

    teclado_atm #(
        .N_PIN(N_PIN),
        .MAX_DIGITOS(MAX_DIG),
        .TIMEOUT_CICLOS(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tecla(tecla),
        .tecla_valida(tecla_valida),
        .tarjeta_recibida(tarjeta_recibida),
        .pin_incorrecto(pin_incorrecto),
        .bloqueo(bloqueo),
        .balance_actualizado(balance_actualizado),
        .entregar_dinero(entregar_dinero),
        .fondos_insuficientes(fondos_insuficientes),
        .digito(digito),
        .digito_stb(digito_stb),
        .tipo_trans(tipo_trans),
        .monto(monto),
        .monto_stb(monto_stb),
        .error_tecla(error_tecla)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        n_chk++;
        if (obs !== req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, req);
        end
    endtask

    function automatic void m_reset();
        m_st = S_IDLE; m_cnt = 0; m_ndig = 0; m_acc = 0;
        m_monto = 0; m_tipo = 0; m_dig = 0;
    endfunction

    // Effect of one key press on the session; returns the expected pulses
    task automatic m_key(input int k, output int ed, output int em, output int ee);
        ed = 0; em = 0; ee = 0;
        case (m_st)
            S_PIN: begin
                if (k < 10) begin
                    ed = 1; m_dig = k; m_cnt++;
                    if (m_cnt == N_PIN) m_st = S_TYPE;
                end else ee = 1;
            end
            S_TYPE: begin
                if (k == 12) begin m_tipo = 0; m_st = S_AMT; end
                else if (k == 13) begin m_tipo = 1; m_st = S_AMT; end
                else ee = 1;
            end
            S_AMT: begin
                if (k < 10) begin
                    if (m_ndig == MAX_DIG) ee = 1;
                    else begin m_acc = m_acc * 10 + k; m_ndig++; end
                end else if (k == 10) begin
                    m_acc = 0; m_ndig = 0;
                end else if (k == 11) begin
                    if (m_ndig > 0) begin em = 1; m_monto = m_acc; m_st = S_IDLE; end
                    else ee = 1;
                end else if (k == 12 || k == 13) begin
                    ee = 1;
                end
            end
            default: ;
        endcase
    endtask

    function automatic void m_ctrl(input int which);
        if (which == C_BLOQ) m_st = S_LOCK;
        else if (m_st != S_LOCK) begin
            if (which == C_PINX || (which == C_CARD && m_st == S_IDLE)) begin
                m_st = S_PIN; m_cnt = 0; m_acc = 0; m_ndig = 0;
            end else if (which == C_BAL || which == C_ENT || which == C_FON) begin
                m_st = S_IDLE;
            end
        end
    endfunction

    task automatic check_holds(input string tag);
        chk({tag, " digito"}, digito, m_dig);
        chk({tag, " tipo_trans"}, tipo_trans, m_tipo);
        chk({tag, " monto"}, monto, m_monto);
    endtask

    task automatic set_ctrl(input int which, input logic v);
        case (which)
            C_BLOQ: bloqueo = v;
            C_PINX: pin_incorrecto = v;
            C_BAL:  balance_actualizado = v;
            C_ENT:  entregar_dinero = v;
            C_FON:  fondos_insuficientes = v;
            default: tarjeta_recibida = v;
        endcase
    endtask

    // Press key k for 'hold' cycles (optionally with fondos_insuficientes on
    // the event cycle), release, then compare pulse counts and held outputs.
    task automatic press_x(input int k, input int hold, input bit with_end);
        int nd = 0, nm = 0, ne = 0, both = 0;
        logic [31:0] mv = '0;
        int ed, em, ee;
        tecla = k[3:0];
        tecla_valida = 1'b1;
        if (with_end) fondos_insuficientes = 1'b1;
        for (int i = 0; i <= hold; i++) begin
            @(negedge clk);
            fondos_insuficientes = 1'b0;
            if (i == hold - 1) tecla_valida = 1'b0;
            if (digito_stb) nd++;
            if (monto_stb) begin nm++; mv = monto; end
            if (error_tecla) ne++;
            if (digito_stb && monto_stb) both++;
        end
        if (with_end) begin
            m_ctrl(C_FON); ed = 0; em = 0; ee = 0;
        end else begin
            m_key(k, ed, em, ee);
        end
        chk("digito_stb pulses", nd, ed);
        chk("monto_stb pulses", nm, em);
        chk("error_tecla pulses", ne, ee);
        chk("strobes together", both, 0);
        if (em != 0) chk("monto at strobe", mv, m_monto);
        check_holds("key");
    endtask

    task automatic press(input int k, input int hold);
        press_x(k, hold, 1'b0);
    endtask

    task automatic ctrl(input int which);
        int n = 0;
        set_ctrl(which, 1'b1);
        @(negedge clk);
        set_ctrl(which, 1'b0);
        if (digito_stb || monto_stb || error_tecla) n++;
        @(negedge clk);
        if (digito_stb || monto_stb || error_tecla) n++;
        m_ctrl(which);
        chk("ctrl no pulses", n, 0);
    endtask

    task automatic enter_pin(input int a, input int b, input int c, input int d);
        press(a, 3); press(b, 3); press(c, 3); press(d, 3);
    endtask

    initial begin
        int k, r;
        m_reset();
        // reset state
        repeat (2) @(negedge clk);
        chk("reset digito", digito, 0);
        chk("reset digito_stb", digito_stb, 0);
        chk("reset tipo_trans", tipo_trans, 0);
        chk("reset monto", monto, 0);
        chk("reset monto_stb", monto_stb, 0);
        chk("reset error_tecla", error_tecla, 0);
        rst = 1'b1;
        @(negedge clk);

        // plan 1: deposit of 10000
        press(5, 2);
        ctrl(C_CARD);
        enter_pin(4, 7, 5, 6);
        chk("t1 last digit", digito, 6);
        press(12, 3);
        press(1, 3); press(0, 3); press(0, 3); press(0, 3); press(0, 3);
        press(11, 3);
        chk("t1 monto", monto, 10000);
        chk("t1 tipo", tipo_trans, 0);
        press(3, 2);

        // plan 2: wrong PIN, retry, withdrawal of 1000
        ctrl(C_CARD);
        enter_pin(4, 7, 5, 7);
        ctrl(C_PINX);
        enter_pin(4, 7, 5, 6);
        press(13, 2);
        press(1, 2); press(0, 2); press(0, 2); press(0, 2);
        press(11, 2);
        chk("t2 tipo", tipo_trans, 1);
        chk("t2 monto", monto, 1000);
        ctrl(C_ENT);

        // plan 3: BORRAR, digit limit, empty ACEPTAR
        ctrl(C_CARD); enter_pin(1, 2, 3, 4); press(12, 1);
        press(9, 1); press(9, 1); press(9, 1); press(10, 1); press(5, 1); press(11, 1);
        chk("t3 monto borrar", monto, 5);
        ctrl(C_CARD); enter_pin(0, 0, 0, 0); press(12, 1);
        for (int i = 0; i < 10; i++) press(9, 1);
        press(11, 1);
        chk("t3 monto max", monto, 999999999);
        ctrl(C_CARD); enter_pin(9, 8, 7, 6); press(13, 1);
        press(11, 2);
        press(12, 1); press(14, 1);
        ctrl(C_BAL);

        // plan 4: bloqueo during PIN, then asynchronous reset mid-cycle
        ctrl(C_CARD);
        press(1, 2); press(2, 2);
        ctrl(C_BLOQ);
        press(3, 2); press(4, 2); press(5, 2); press(6, 2); press(13, 2);
        ctrl(C_PINX); ctrl(C_CARD);
        press(7, 2);
        #2 rst = 1'b0;
        #1;
        chk("async rst digito", digito, 0);
        chk("async rst tipo", tipo_trans, 0);
        chk("async rst monto", monto, 0);
        chk("async rst strobes", {digito_stb, monto_stb, error_tecla}, 0);
        @(negedge clk);
        rst = 1'b1;
        m_reset();
        @(negedge clk);
        press(4, 2);
        ctrl(C_CARD); enter_pin(2, 4, 6, 8); press(13, 1);
        press(4, 1); press(2, 1); press(11, 1);
        chk("t4 monto after reset", monto, 42);

        // plan 5: long hold, key coincident with fondos_insuficientes
        ctrl(C_CARD);
        press(4, 20);
        press(10, 20);
        enter_pin(1, 1, 1, 1);
        press(12, 1); press(8, 1);
        press_x(5, 3, 1'b1);
        press(6, 2);
        press(11, 2);
        ctrl(C_CARD); enter_pin(3, 3, 3, 3); press(12, 1); press(7, 1); press(11, 1);
        chk("t5 monto after end", monto, 7);

`ifdef TECLADO_TIMEOUT_EN
        begin
            int ne = 0;
            ctrl(C_CARD); enter_pin(5, 5, 5, 5); press(12, 1); press(3, 1);
            for (int i = 0; i < TMO + 20; i++) begin
                @(negedge clk);
                if (error_tecla) ne++;
            end
            chk("timeout error pulses", ne, 1);
            m_st = S_IDLE; m_cnt = 0; m_acc = 0; m_ndig = 0;
            press(11, 1);
            press(5, 1);
        end
`endif

        // randomized sessions
        for (int s = 0; s < 12; s++) begin
            if (m_st != S_IDLE) ctrl(C_BAL);
            ctrl(C_CARD);
            for (int j = 0; j < 40 && m_st != S_IDLE; j++) begin
                case (m_st)
                    S_PIN: begin
                        if ($urandom_range(0, 19) == 0) ctrl(C_PINX);
                        k = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15))
                                                        : int'($urandom_range(0, 9));
                    end
                    S_TYPE: begin
                        k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                                        : 12 + int'($urandom_range(0, 1));
                    end
                    default: begin
                        r = $urandom_range(0, 19);
                        if (r < 12) k = r % 10;
                        else if (r == 12) k = 10;
                        else if (r < 17) k = 11;
                        else if (r == 17) k = 12;
                        else if (r == 18) k = 13;
                        else k = $urandom_range(0, 9);
                    end
                endcase
                press(k, $urandom_range(1, 4));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
